// File: rtl/sim_sram_tl_steer.sv
// -----------------------------------------------------------------------------
// sim_sram_tl_steer_pkg
//   Minimal TL-UL channel structs shared by the steering block and its bench.
//   The a_user / d_user fields carry the bus integrity bits. They are copied
//   through unchanged.
//
// sim_sram_tl_steer
//   Simulation-only front end for the sim SRAM. One host TL-UL port comes in.
//   Each request goes out on one of two ports, chosen by an address window that
//   is programmed at runtime:
//     - tl_sim_o / tl_sim_i : requests inside the window (when en_i = 1)
//     - tl_dev_o / tl_dev_i : everything else
//   All in-flight requests must target the same side. This keeps responses in
//   request order without a reorder buffer. A request for the other side waits
//   until the current side has drained completely.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            window enable; 0 routes all traffic to the device port
//   base_i          window base; the bits below log2(SizeBytes) are ignored
//   tl_h_i/tl_h_o   host side request / response
//   tl_sim_o/_i     sim SRAM side
//   tl_dev_o/_i     device fabric side
//   outstanding_o   current in-flight count (debug / coverage)
//
// Handshake: strict TL-UL valid/ready. A beat transfers in any cycle where
// valid and ready are both high at the rising clock edge. Both A and D paths
// are purely combinational. The only state is the outstanding count and the
// side that owns the in-flight transactions.
// -----------------------------------------------------------------------------
package sim_sram_tl_steer_pkg;

  localparam int TlAw = 32;
  localparam int TlDw = 32;
  localparam int TlSw = 8;
  localparam int TlUw = 14;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TlSw-1:0]   a_source;
    logic [TlAw-1:0]   a_address;
    logic [TlDw/8-1:0] a_mask;
    logic [TlDw-1:0]   a_data;
    logic [TlUw-1:0]   a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic            d_valid;
    logic [2:0]      d_opcode;
    logic [2:0]      d_param;
    logic [1:0]      d_size;
    logic [TlSw-1:0] d_source;
    logic            d_sink;
    logic [TlDw-1:0] d_data;
    logic [TlUw-1:0] d_user;
    logic            d_error;
    logic            a_ready;
  } tl_d2h_t;

endpackage

module sim_sram_tl_steer
  import sim_sram_tl_steer_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int SizeBytes      = 4096,
  parameter int MaxOutstanding = 4,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] base_i,
  input  tl_h2d_t              tl_h_i,
  output tl_d2h_t              tl_h_o,
  output tl_h2d_t              tl_sim_o,
  input  tl_d2h_t              tl_sim_i,
  output tl_h2d_t              tl_dev_o,
  input  tl_d2h_t              tl_dev_i,
  output logic [CntW-1:0]      outstanding_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time checks
  // ---------------------------------------------------------------------------
`ifdef SYNTHESIS
  if (1) begin : gen_sim_only
    $error("sim_sram_tl_steer is a simulation-only block and must not be synthesized");
  end
`endif

  if ((SizeBytes < 4) || ((SizeBytes & (SizeBytes - 1)) != 0)) begin : gen_bad_size
    $error("SizeBytes must be a power of two and at least 4");
  end

  if (MaxOutstanding < 1) begin : gen_bad_outstanding
    $error("MaxOutstanding must be at least 1");
  end

  if (AddrWidth != TlAw) begin : gen_bad_addr_width
    $error("AddrWidth must match the TL-UL address width");
  end

  // ---------------------------------------------------------------------------
  // Window decode
  // ---------------------------------------------------------------------------
  typedef enum logic {
    SideDev = 1'b0,
    SideSim = 1'b1
  } side_e;

  // Keeps only the address bits above the window offset.
  localparam logic [AddrWidth-1:0] WinMask = ~(AddrWidth'(SizeBytes - 1));
  localparam logic [CntW-1:0]      CntMax  = CntW'(MaxOutstanding);

  logic  hit;
  side_e target;

  assign hit    = en_i & ((tl_h_i.a_address & WinMask) == (base_i & WinMask));
  assign target = hit ? SideSim : SideDev;

  // ---------------------------------------------------------------------------
  // Ownership state
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  side_e           dir_q, dir_d;

  logic at_max;
  logic stall;
  logic a_acc;
  logic d_acc;

  assign at_max = (cnt_q == CntMax);
  // Stall uses registered state only. A switch of side therefore lands in the
  // cycle after the last response handshake of the old side.
  assign stall  = at_max | ((cnt_q != '0) & (target != dir_q));

  // ---------------------------------------------------------------------------
  // Channel steering
  // ---------------------------------------------------------------------------
  always_comb begin
    // Both sides see the host A fields. Only the target side gets a_valid.
    tl_sim_o         = tl_h_i;
    tl_dev_o         = tl_h_i;
    tl_sim_o.a_valid = 1'b0;
    tl_dev_o.a_valid = 1'b0;
    tl_sim_o.d_ready = 1'b0;
    tl_dev_o.d_ready = 1'b0;

    if (target == SideSim) begin
      tl_sim_o.a_valid = tl_h_i.a_valid & ~stall;
    end else begin
      tl_dev_o.a_valid = tl_h_i.a_valid & ~stall;
    end

    // The D channel follows the side that owns the in-flight traffic.
    if (dir_q == SideSim) begin
      tl_sim_o.d_ready = tl_h_i.d_ready;
      tl_h_o           = tl_sim_i;
    end else begin
      tl_dev_o.d_ready = tl_h_i.d_ready;
      tl_h_o           = tl_dev_i;
    end

    // a_ready always comes from the target side, which may differ from dir_q.
    tl_h_o.a_ready = ((target == SideSim) ? tl_sim_i.a_ready : tl_dev_i.a_ready) & ~stall;
  end

  assign a_acc = tl_h_i.a_valid & tl_h_o.a_ready;
  assign d_acc = tl_h_o.d_valid & tl_h_i.d_ready;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (a_acc && !d_acc) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (d_acc && !a_acc) begin
      cnt_d = cnt_q - CntW'(1);
    end
    if (a_acc) begin
      dir_d = target;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      dir_q <= SideDev;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign outstanding_o = cnt_q;

  // ---------------------------------------------------------------------------
  // Protocol assertions
  // ---------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (a_acc && !d_acc) |-> !at_max)
    else $error("outstanding counter incremented at MaxOutstanding");

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (d_acc && !a_acc) |-> (cnt_q != '0))
    else $error("outstanding counter decremented at zero");

  // A response may only come from the owning side, and only while it owns
  // traffic.
  a_sim_d_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_sim_i.d_valid |-> ((cnt_q != '0) && (dir_q == SideSim)))
    else $error("sim side raised d_valid without owning in-flight traffic");

  a_dev_d_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_dev_i.d_valid |-> ((cnt_q != '0) && (dir_q == SideDev)))
    else $error("device side raised d_valid without owning in-flight traffic");

endmodule

// File: tb/tb_sim_sram_tl_steer.sv
// -----------------------------------------------------------------------------
// Bench for sim_sram_tl_steer. The two downstream ports are served by simple
// responders that queue whatever requests the DUT hands them. The bench also
// keeps its own model of in-flight traffic: an ordered list recording the side
// each accepted request went to. Every expected value comes from that model
// and from the window rule.
// -----------------------------------------------------------------------------
module tb_sim_sram_tl_steer;
  import sim_sram_tl_steer_pkg::*;

  localparam int AW  = 32;
  localparam int SB  = 4096;
  localparam int MO  = 4;
  localparam int OFF = $clog2(SB);
  localparam int CW  = $clog2(MO + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] base;
  tl_h2d_t       h_i;
  tl_d2h_t       h_o;
  tl_h2d_t       sim_o;
  tl_d2h_t       sim_i;
  tl_h2d_t       dev_o;
  tl_d2h_t       dev_i;
  logic [CW-1:0] outstanding;

  always #5 clk = ~clk;

  sim_sram_tl_steer #(
    .AddrWidth      (AW),
    .SizeBytes      (SB),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .base_i        (base),
    .tl_h_i        (h_i),
    .tl_h_o        (h_o),
    .tl_sim_o      (sim_o),
    .tl_sim_i      (sim_i),
    .tl_dev_o      (dev_o),
    .tl_dev_i      (dev_i),
    .outstanding_o (outstanding)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic sim_a_ready, dev_a_ready, sim_resp_on, dev_resp_on;

  // Responder queues hold what the DUT actually delivered downstream.
  logic [7:0]  sim_src_q[$], dev_src_q[$];
  logic [31:0] sim_addr_q[$], dev_addr_q[$];

  // Reference model: side of every in-flight request (1 = SIM), oldest first.
  bit          m_side_q[$];
  logic [7:0]  exp_src_q[$];
  logic [31:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return en && ((a >> OFF) == (base >> OFF));
  endfunction

  // Each side tags its read data, so the bench can tell which side answered.
  function automatic logic [31:0] resp_data(input bit side, input logic [31:0] a);
    return side ? {8'h51, a[23:0]} : {8'hDE, a[23:0]};
  endfunction

  function automatic logic [13:0] resp_user(input bit side);
    return side ? 14'h1234 : 14'h0abc;
  endfunction

  task automatic drive_resp();
    sim_i         = '0;
    dev_i         = '0;
    sim_i.a_ready = sim_a_ready;
    dev_i.a_ready = dev_a_ready;
    if (sim_resp_on && sim_src_q.size() > 0) begin
      sim_i.d_valid  = 1'b1;
      sim_i.d_opcode = 3'd1;
      sim_i.d_source = sim_src_q[0];
      sim_i.d_data   = resp_data(1'b1, sim_addr_q[0]);
      sim_i.d_user   = resp_user(1'b1);
    end
    if (dev_resp_on && dev_src_q.size() > 0) begin
      dev_i.d_valid  = 1'b1;
      dev_i.d_opcode = 3'd1;
      dev_i.d_source = dev_src_q[0];
      dev_i.d_data   = resp_data(1'b0, dev_addr_q[0]);
      dev_i.d_user   = resp_user(1'b0);
    end
  endtask

  task automatic set_req(input logic [31:0] addr, input logic [7:0] src, input bit write);
    h_i.a_valid   = 1'b1;
    h_i.a_opcode  = write ? 3'd0 : 3'd4;
    h_i.a_param   = 3'd0;
    h_i.a_size    = 2'd2;
    h_i.a_source  = src;
    h_i.a_address = addr;
    h_i.a_mask    = 4'hf;
    h_i.a_data    = $urandom;
    h_i.a_user    = 14'($urandom);
  endtask

  task automatic clr_req();
    h_i.a_valid = 1'b0;
  endtask

  // One clock cycle. Called at a negedge with the host inputs already set. It
  // checks the combinational outputs against the model, then lets the edge
  // happen and updates the model. It returns at the next negedge.
  task automatic tick(output bit a_acc, output bit d_acc);
    bit   tgt, can, exp_ar, exp_dv;
    bit   sim_take, dev_take, sim_pop, dev_pop;
    int   n;
    drive_resp();
    #1;
    n   = m_side_q.size();
    tgt = model_hit(h_i.a_address);
    // A request may go out only if there is room and every in-flight request
    // went to the same side.
    can = (n < MO);
    foreach (m_side_q[i]) if (m_side_q[i] != tgt) can = 1'b0;
    exp_ar = can && (tgt ? sim_a_ready : dev_a_ready);
    a_acc  = h_i.a_valid && exp_ar;
    exp_dv = (n > 0) && (m_side_q[0] ? sim_resp_on : dev_resp_on);
    d_acc  = exp_dv && h_i.d_ready;

    chk("outstanding", 32'(outstanding), 32'(n));
    chk("sim_a_valid", 32'(sim_o.a_valid), 32'(h_i.a_valid && tgt && can));
    chk("dev_a_valid", 32'(dev_o.a_valid), 32'(h_i.a_valid && !tgt && can));
    chk("host_a_ready", 32'(h_o.a_ready), 32'(exp_ar));
    chk("host_d_valid", 32'(h_o.d_valid), 32'(exp_dv));
    if (h_i.a_valid) begin
      chk("tgt_a_address", tgt ? sim_o.a_address : dev_o.a_address, h_i.a_address);
      chk("tgt_a_user", 32'(tgt ? sim_o.a_user : dev_o.a_user), 32'(h_i.a_user));
    end
    if (n > 0) begin
      chk("sim_d_ready", 32'(sim_o.d_ready), 32'(m_side_q[0] && h_i.d_ready));
      chk("dev_d_ready", 32'(dev_o.d_ready), 32'(!m_side_q[0] && h_i.d_ready));
    end
    if (exp_dv) begin
      chk("host_d_source", 32'(h_o.d_source), 32'(exp_src_q[0]));
      chk("host_d_data", h_o.d_data, exp_q[0]);
      chk("host_d_user", 32'(h_o.d_user), 32'(resp_user(m_side_q[0])));
    end

    sim_take = sim_o.a_valid && sim_a_ready;
    dev_take = dev_o.a_valid && dev_a_ready;
    sim_pop  = sim_i.d_valid && sim_o.d_ready;
    dev_pop  = dev_i.d_valid && dev_o.d_ready;

    @(posedge clk);
    if (sim_take) begin
      sim_src_q.push_back(sim_o.a_source);
      sim_addr_q.push_back(sim_o.a_address);
    end
    if (dev_take) begin
      dev_src_q.push_back(dev_o.a_source);
      dev_addr_q.push_back(dev_o.a_address);
    end
    if (sim_pop && sim_src_q.size() > 0) begin
      void'(sim_src_q.pop_front());
      void'(sim_addr_q.pop_front());
    end
    if (dev_pop && dev_src_q.size() > 0) begin
      void'(dev_src_q.pop_front());
      void'(dev_addr_q.pop_front());
    end
    if (d_acc && m_side_q.size() > 0) begin
      void'(m_side_q.pop_front());
      void'(exp_src_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (a_acc) begin
      m_side_q.push_back(tgt);
      exp_src_q.push_back(h_i.a_source);
      exp_q.push_back(resp_data(tgt, h_i.a_address));
    end
    @(negedge clk);
  endtask

  // Present one request and hold it until it is accepted or the budget runs out.
  task automatic send(input logic [31:0] addr, input logic [7:0] src, input bit write,
                      input int budget);
    bit aa, da;
    int waited;
    set_req(addr, src, write);
    aa     = 1'b0;
    waited = 0;
    while (!aa && waited < budget) begin
      tick(aa, da);
      waited++;
    end
    chk("send_accepted", 32'(aa), 32'd1);
    clr_req();
  endtask

  task automatic drain(input int budget);
    bit aa, da;
    int waited;
    clr_req();
    h_i.d_ready = 1'b1;
    sim_resp_on = 1'b1;
    dev_resp_on = 1'b1;
    waited      = 0;
    while (m_side_q.size() > 0 && waited < budget) begin
      tick(aa, da);
      waited++;
    end
    chk("drain_empty", 32'(m_side_q.size()), 32'd0);
  endtask

  task automatic clear_all_queues();
    m_side_q.delete();
    exp_src_q.delete();
    exp_q.delete();
    sim_src_q.delete();
    sim_addr_q.delete();
    dev_src_q.delete();
    dev_addr_q.delete();
  endtask

  // Time limit on the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit          aa, da;
    logic [31:0] a;

    rst_n       = 1'b0;
    en          = 1'b0;
    base        = '0;
    h_i         = '0;
    sim_i       = '0;
    dev_i       = '0;
    sim_a_ready = 1'b1;
    dev_a_ready = 1'b1;
    sim_resp_on = 1'b0;
    dev_resp_on = 1'b0;

    // Reset state: count is 0. The D path follows the device side, and A
    // passes straight through.
    @(negedge clk);
    dev_i.d_valid  = 1'b1;
    dev_i.d_source = 8'h77;
    sim_i.d_valid  = 1'b1;
    sim_i.d_source = 8'h33;
    h_i.a_valid    = 1'b1;
    h_i.a_address  = 32'h1000_0000;
    #1;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_d_valid", 32'(h_o.d_valid), 32'd1);
    chk("rst_d_source", 32'(h_o.d_source), 32'h77);
    chk("rst_dev_a_valid", 32'(dev_o.a_valid), 32'd1);
    chk("rst_sim_a_valid", 32'(sim_o.a_valid), 32'd0);
    sim_i = '0;
    dev_i = '0;
    h_i   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Window routing
    en          = 1'b1;
    base        = 32'h1000_0000;
    h_i.d_ready = 1'b1;
    send(32'h1000_0ffc, 8'd1, 1'b1, 4);
    chk("win_sim_got", 32'(sim_src_q.size()), 32'd1);
    chk("win_dev_none", 32'(dev_src_q.size()), 32'd0);
    drain(10);
    send(32'h1000_1000, 8'd2, 1'b1, 4);
    chk("win_dev_got", 32'(dev_src_q.size()), 32'd1);
    chk("win_sim_none", 32'(sim_src_q.size()), 32'd0);
    drain(10);

    // Disabled window
    en = 1'b0;
    send(32'h1000_0000, 8'd3, 1'b0, 4);
    chk("dis_dev_got", 32'(dev_src_q.size()), 32'd1);
    chk("dis_sim_none", 32'(sim_src_q.size()), 32'd0);
    drain(10);

    // Full stall with four SIM reads outstanding
    en          = 1'b1;
    h_i.d_ready = 1'b0;
    sim_resp_on = 1'b0;
    dev_resp_on = 1'b0;
    for (int i = 0; i < MO; i++) send(32'h1000_0000 + 32'(4 * i), 8'(10 + i), 1'b0, 4);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    set_req(32'h1000_0010, 8'd14, 1'b0);
    tick(aa, da);
    chk("full_5th_blocked", 32'(aa), 32'd0);
    h_i.d_ready = 1'b1;
    sim_resp_on = 1'b1;
    tick(aa, da);
    chk("full_release_d", 32'(da), 32'd1);
    chk("full_release_a", 32'(aa), 32'd0);
    h_i.d_ready = 1'b0;
    sim_resp_on = 1'b0;
    tick(aa, da);
    chk("full_5th_next", 32'(aa), 32'd1);
    clr_req();
    drain(20);

    // Side switch: SIM, SIM, then a DEV request that has to wait
    h_i.d_ready = 1'b0;
    sim_resp_on = 1'b0;
    dev_resp_on = 1'b0;
    send(32'h1000_0100, 8'd20, 1'b0, 4);
    send(32'h1000_0104, 8'd21, 1'b0, 4);
    set_req(32'h2000_0000, 8'd22, 1'b0);
    tick(aa, da);
    chk("sw_dev_stalled", 32'(aa), 32'd0);
    h_i.d_ready = 1'b1;
    sim_resp_on = 1'b1;
    dev_resp_on = 1'b1;
    tick(aa, da);
    chk("sw_d1", 32'(da), 32'd1);
    chk("sw_a1", 32'(aa), 32'd0);
    tick(aa, da);
    chk("sw_d2", 32'(da), 32'd1);
    chk("sw_a2", 32'(aa), 32'd0);
    tick(aa, da);
    chk("sw_a3", 32'(aa), 32'd1);
    clr_req();
    drain(10);

    // Simultaneous A accept and D accept
    sim_resp_on = 1'b0;
    send(32'h1000_0200, 8'd30, 1'b0, 4);
    set_req(32'h1000_0204, 8'd31, 1'b0);
    sim_resp_on = 1'b1;
    tick(aa, da);
    chk("sim_both_a", 32'(aa), 32'd1);
    chk("sim_both_d", 32'(da), 32'd1);
    clr_req();
    #1;
    chk("sim_both_cnt", 32'(outstanding), 32'd1);
    drain(10);

    // Runtime window change with three SIM requests in flight
    sim_resp_on = 1'b0;
    h_i.d_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h1000_0300 + 32'(4 * i), 8'(40 + i), 1'b0, 4);
    base = 32'h3000_0000;
    drain(20);
    base = 32'h1000_0000;

    // Reset in the middle of a transaction
    sim_resp_on = 1'b0;
    send(32'h1000_0400, 8'd50, 1'b0, 4);
    send(32'h1000_0404, 8'd51, 1'b0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    sim_i.d_valid  = 1'b1;
    sim_i.d_source = 8'h44;
    dev_i.d_valid  = 1'b1;
    dev_i.d_source = 8'h55;
    #1;
    chk("mid_rst_dir_dev", 32'(h_o.d_source), 32'h55);
    clear_all_queues();
    sim_i = '0;
    dev_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      sim_a_ready = ($urandom_range(0, 9) < 7);
      dev_a_ready = ($urandom_range(0, 9) < 7);
      sim_resp_on = ($urandom_range(0, 9) < 6);
      dev_resp_on = ($urandom_range(0, 9) < 6);
      h_i.d_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) base = ($urandom_range(0, 1) != 0) ? 32'h1000_0000 : 32'h1000_2000;
      if ($urandom_range(0, 99) < 3) en = ~en;
      if (!h_i.a_valid && $urandom_range(0, 9) < 6) begin
        a = (base & ~32'(SB - 1)) + 32'(SB) - 32'(SB) * 32'($urandom_range(0, 2))
            + 32'($urandom_range(0, SB / 4 - 1) * 4);
        set_req(a, 8'($urandom_range(0, 255)), $urandom_range(0, 1) != 0);
      end
      tick(aa, da);
      if (aa) clr_req();
    end
    sim_a_ready = 1'b1;
    dev_a_ready = 1'b1;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
